m_column_stack_tracker: RTL and testbench

- Registered, parametrised successor to the combinational per-column piled counter for the drop-piece board.
- Holds the pile height of every column and accepts DROP, UNDO and CLEAR requests over a valid/ready handshake.
- Keeps a move-history stack so UNDO removes the most recent piece.
- Returns a one-cycle response pulse; sits between the game controller and the board renderer.

---
 rtl/m_column_stack_tracker_if.sv | 40 ++++
 rtl/m_column_stack_tracker.sv | 176 +++++++++++++++++
 tb/tb_m_column_stack_tracker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/m_column_stack_tracker_if.sv
// Request/response/status bundle between the game controller and the
// column stack tracker. The controller side uses the master modport, the
// tracker uses the slave modport.
interface m_column_stack_tracker_if #(
    parameter int NUM_COLS  = 7,
    parameter int NUM_ROWS  = 6,
    parameter int H_W       = $clog2(NUM_ROWS + 1),
    parameter int COL_W     = $clog2(NUM_COLS),
    parameter int MAX_MOVES = NUM_COLS * NUM_ROWS,
    parameter int MC_W      = $clog2(MAX_MOVES + 1)
);
    // request channel
    logic                       i_req_valid;
    logic                       o_req_ready;
    logic [1:0]                 i_req_op;
    logic [COL_W-1:0]           i_req_col;
    // response channel
    logic                       o_rsp_valid;
    logic                       o_rsp_ok;
    logic [1:0]                 o_rsp_op;
    logic [COL_W-1:0]           o_rsp_col;
    logic [H_W-1:0]             o_rsp_row;
    // board status
    logic [NUM_COLS*H_W-1:0]    o_heights;
    logic [NUM_COLS-1:0]        o_col_full;
    logic [MC_W-1:0]            o_move_count;
    logic                       o_board_full;

    modport master (
        output i_req_valid, i_req_op, i_req_col,
        input  o_req_ready, o_rsp_valid, o_rsp_ok, o_rsp_op, o_rsp_col, o_rsp_row,
        input  o_heights, o_col_full, o_move_count, o_board_full
    );

    modport slave (
        input  i_req_valid, i_req_op, i_req_col,
        output o_req_ready, o_rsp_valid, o_rsp_ok, o_rsp_op, o_rsp_col, o_rsp_row,
        output o_heights, o_col_full, o_move_count, o_board_full
    );
endinterface

// File: rtl/m_column_stack_tracker.sv
// Per-column pile height tracker for the drop-piece board. Accepts DROP,
// UNDO and CLEAR requests, keeps a move-history stack for UNDO, and answers
// each request with a one-cycle registered response pulse. CLEAR walks the
// columns one per cycle while requests are held off.
module m_column_stack_tracker #(
    parameter int NUM_COLS  = 7,
    parameter int NUM_ROWS  = 6,
    parameter int H_W       = $clog2(NUM_ROWS + 1),
    parameter int COL_W     = $clog2(NUM_COLS),
    parameter int MAX_MOVES = NUM_COLS * NUM_ROWS,
    parameter int MC_W      = $clog2(MAX_MOVES + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    m_column_stack_tracker_if.slave bus
);

    localparam logic [1:0] OP_DROP  = 2'b00;
    localparam logic [1:0] OP_UNDO  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    localparam logic [COL_W:0]   NUM_COLS_W = (COL_W + 1)'(NUM_COLS);
    localparam logic [H_W-1:0]   ROWS_H     = H_W'(NUM_ROWS);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);
    localparam logic [MC_W-1:0]  MAX_MC     = MC_W'(MAX_MOVES);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t             state_reg, state_next;
    logic [COL_W-1:0]   clr_idx_reg, clr_idx_next;
    logic [MC_W-1:0]    mc_reg, mc_next;            // doubles as stack pointer
    logic [H_W-1:0]     heights_reg  [NUM_COLS];
    logic [H_W-1:0]     heights_next [NUM_COLS];
    logic [COL_W-1:0]   stack_reg    [MAX_MOVES];

    logic               rsp_valid_reg, rsp_valid_next;
    logic               rsp_ok_reg, rsp_ok_next;
    logic [1:0]         rsp_op_reg, rsp_op_next;
    logic [COL_W-1:0]   rsp_col_reg, rsp_col_next;
    logic [H_W-1:0]     rsp_row_reg, rsp_row_next;

    logic               push_en;
    logic [COL_W-1:0]   push_col;

    // Helper selects; indices are forced in range so no read goes off an array end
    logic               col_in_range;
    logic [COL_W-1:0]   drop_idx;
    logic [H_W-1:0]     drop_height;
    logic [MC_W-1:0]    top_idx;
    logic [COL_W-1:0]   undo_col;

    assign col_in_range = ({1'b0, bus.i_req_col} < NUM_COLS_W);
    assign drop_idx     = col_in_range ? bus.i_req_col : '0;
    assign drop_height  = heights_reg[drop_idx];
    assign top_idx      = (mc_reg == '0) ? '0 : (mc_reg - MC_W'(1));
    assign undo_col     = stack_reg[top_idx];

    // Next-state and response logic for the IDLE/CLEAR controller
    always_comb begin
        state_next     = state_reg;
        clr_idx_next   = clr_idx_reg;
        mc_next        = mc_reg;
        heights_next   = heights_reg;
        rsp_valid_next = 1'b0;
        rsp_ok_next    = 1'b0;
        rsp_op_next    = '0;
        rsp_col_next   = '0;
        rsp_row_next   = '0;
        push_en        = 1'b0;
        push_col       = bus.i_req_col;

        case (state_reg)
            ST_IDLE: begin
                if (bus.i_req_valid) begin
                    rsp_valid_next = 1'b1;
                    rsp_op_next    = bus.i_req_op;
                    case (bus.i_req_op)
                        OP_DROP: begin
                            rsp_col_next = bus.i_req_col;
                            if (col_in_range && (drop_height < ROWS_H)) begin
                                heights_next[drop_idx] = drop_height + H_W'(1);
                                push_en      = 1'b1;
                                mc_next      = mc_reg + MC_W'(1);
                                rsp_ok_next  = 1'b1;
                                rsp_row_next = drop_height;
                            end
                        end
                        OP_UNDO: begin
                            if (mc_reg != '0) begin
                                heights_next[undo_col] = heights_reg[undo_col] - H_W'(1);
                                mc_next      = mc_reg - MC_W'(1);
                                rsp_ok_next  = 1'b1;
                                rsp_col_next = undo_col;
                                rsp_row_next = heights_reg[undo_col] - H_W'(1);
                            end
                        end
                        OP_CLEAR: begin
                            // Response is deferred until the column sweep ends
                            rsp_valid_next = 1'b0;
                            mc_next        = '0;
                            clr_idx_next   = '0;
                            state_next     = ST_CLEAR;
                        end
                        default: ;  // reserved op: rejected, no state change
                    endcase
                end
            end
            ST_CLEAR: begin
                heights_next[clr_idx_reg] = '0;
                clr_idx_next = clr_idx_reg + COL_W'(1);
                if (clr_idx_reg == LAST_COL) begin
                    state_next     = ST_IDLE;
                    clr_idx_next   = '0;
                    rsp_valid_next = 1'b1;
                    rsp_ok_next    = 1'b1;
                    rsp_op_next    = OP_CLEAR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counters, heights and response registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            clr_idx_reg   <= '0;
            mc_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_ok_reg    <= 1'b0;
            rsp_op_reg    <= '0;
            rsp_col_reg   <= '0;
            rsp_row_reg   <= '0;
            for (int c = 0; c < NUM_COLS; c++) begin
                heights_reg[c] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            clr_idx_reg   <= clr_idx_next;
            mc_reg        <= mc_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_ok_reg    <= rsp_ok_next;
            rsp_op_reg    <= rsp_op_next;
            rsp_col_reg   <= rsp_col_next;
            rsp_row_reg   <= rsp_row_next;
            for (int c = 0; c < NUM_COLS; c++) begin
                heights_reg[c] <= heights_next[c];
            end
        end
    end

    // Move-history stack; entries above the pointer are don't-care, so no reset
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            stack_reg[mc_reg] <= push_col;
        end
    end

    // Status outputs straight from registers
    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col_out
            assign bus.o_heights[gi*H_W +: H_W] = heights_reg[gi];
            assign bus.o_col_full[gi]           = (heights_reg[gi] == ROWS_H);
        end
    endgenerate

    assign bus.o_req_ready  = (state_reg == ST_IDLE);
    assign bus.o_rsp_valid  = rsp_valid_reg;
    assign bus.o_rsp_ok     = rsp_ok_reg;
    assign bus.o_rsp_op     = rsp_op_reg;
    assign bus.o_rsp_col    = rsp_col_reg;
    assign bus.o_rsp_row    = rsp_row_reg;
    assign bus.o_move_count = mc_reg;
    assign bus.o_board_full = (mc_reg == MAX_MC);

endmodule

// File: tb/tb_m_column_stack_tracker.sv
// Self-checking bench for m_column_stack_tracker: directed scenarios followed
// by randomized traffic, checked against a column/history model.
module tb_m_column_stack_tracker;

    localparam int NUM_COLS  = 7;
    localparam int NUM_ROWS  = 6;
    localparam int H_W       = 3;
    localparam int MAX_MOVES = 42;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    m_column_stack_tracker_if #(.NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS)) bus ();

    m_column_stack_tracker #(
        .NUM_COLS(NUM_COLS),
        .NUM_ROWS(NUM_ROWS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pile height per column and the ordered list of drops
    int mh [NUM_COLS];
    int hist [$];

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_heights();
        int v = 0;
        for (int c = 0; c < NUM_COLS; c++) v += mh[c] * (1 << (H_W * c));
        return v;
    endfunction

    function automatic int model_full();
        int v = 0;
        for (int c = 0; c < NUM_COLS; c++) if (mh[c] == NUM_ROWS) v += (1 << c);
        return v;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_COLS; c++) mh[c] = 0;
        hist.delete();
    endfunction

    task automatic check_status();
        check_val("heights",    int'(bus.o_heights),    model_heights());
        check_val("col_full",   int'(bus.o_col_full),   model_full());
        check_val("move_count", int'(bus.o_move_count), hist.size());
        check_val("board_full", int'(bus.o_board_full), (hist.size() == MAX_MOVES) ? 1 : 0);
    endtask

    // Present one request for one cycle (valid is left high; caller drops it)
    task automatic send(input logic [1:0] op, input logic [2:0] col);
        int eok, ecol, erow;
        bus.i_req_valid = 1'b1;
        bus.i_req_op    = op;
        bus.i_req_col   = col;
        check_val("req_ready", int'(bus.o_req_ready), 1);
        eok = 0; ecol = 0; erow = 0;
        if (op == 2'b00) begin
            ecol = int'(col);
            if (int'(col) < NUM_COLS && mh[col] < NUM_ROWS) begin
                eok = 1;
                erow = mh[col];
                mh[col]++;
                hist.push_back(int'(col));
            end
        end else if (op == 2'b01) begin
            if (hist.size() > 0) begin
                ecol = hist.pop_back();
                mh[ecol]--;
                erow = mh[ecol];
                eok = 1;
            end
        end
        @(posedge clk);
        #1;
        $display("req op=%0d col=%0d -> valid=%0d ok=%0d col=%0d row=%0d cnt=%0d",
                 op, col, bus.o_rsp_valid, bus.o_rsp_ok, bus.o_rsp_col, bus.o_rsp_row,
                 bus.o_move_count);
        check_val("rsp_valid", int'(bus.o_rsp_valid), 1);
        check_val("rsp_ok",    int'(bus.o_rsp_ok),    eok);
        check_val("rsp_op",    int'(bus.o_rsp_op),    int'(op));
        if (op != 2'b11) begin
            check_val("rsp_col", int'(bus.o_rsp_col), ecol);
            check_val("rsp_row", int'(bus.o_rsp_row), erow);
        end
        check_status();
    endtask

    task automatic idle(input int n);
        bus.i_req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check_val("idle_rsp_valid", int'(bus.o_rsp_valid), 0);
        end
    endtask

    // CLEAR: ready low for NUM_COLS cycles, response in the following cycle
    task automatic clear_board();
        bus.i_req_valid = 1'b1;
        bus.i_req_op    = 2'b10;
        bus.i_req_col   = 3'($urandom_range(0, 7));
        check_val("clr_ready_in", int'(bus.o_req_ready), 1);
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
        model_reset();
        check_val("clr_count", int'(bus.o_move_count), 0);
        for (int i = 0; i < NUM_COLS; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            check_val("clr_ready_low", int'(bus.o_req_ready), 0);
            check_val("clr_no_rsp",    int'(bus.o_rsp_valid), 0);
        end
        @(posedge clk);
        #1;
        $display("req op=2 -> valid=%0d ok=%0d ready=%0d heights=%0h cnt=%0d",
                 bus.o_rsp_valid, bus.o_rsp_ok, bus.o_req_ready, bus.o_heights,
                 bus.o_move_count);
        check_val("clr_rsp_valid", int'(bus.o_rsp_valid), 1);
        check_val("clr_rsp_ok",    int'(bus.o_rsp_ok),    1);
        check_val("clr_rsp_op",    int'(bus.o_rsp_op),    2);
        check_val("clr_rsp_col",   int'(bus.o_rsp_col),   0);
        check_val("clr_rsp_row",   int'(bus.o_rsp_row),   0);
        check_val("clr_ready_out", int'(bus.o_req_ready), 1);
        check_status();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_ready"},   int'(bus.o_req_ready),  1);
        check_val({tag, "_rvalid"},  int'(bus.o_rsp_valid),  0);
        check_val({tag, "_rok"},     int'(bus.o_rsp_ok),     0);
        check_val({tag, "_rop"},     int'(bus.o_rsp_op),     0);
        check_val({tag, "_rcol"},    int'(bus.o_rsp_col),    0);
        check_val({tag, "_rrow"},    int'(bus.o_rsp_row),    0);
        check_val({tag, "_heights"}, int'(bus.o_heights),    0);
        check_val({tag, "_count"},   int'(bus.o_move_count), 0);
        check_val({tag, "_full"},    int'(bus.o_col_full),   0);
    endtask

    initial begin
        int r;
        bus.i_req_valid = 1'b0;
        bus.i_req_op    = 2'b00;
        bus.i_req_col   = '0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill column 3, then one more drop is rejected
        for (int i = 0; i < 7; i++) send(2'b00, 3'd3);
        check_val("col3_height", int'(bus.o_heights[11:9]), 6);
        check_val("col3_full",   int'(bus.o_col_full[3]),   1);
        idle(1);

        // Out-of-range column and reserved op
        send(2'b00, 3'd7);
        send(2'b11, 3'd1);
        idle(1);

        // Drops then unwinding undos, with one undo too many
        clear_board();
        send(2'b00, 3'd2);
        send(2'b00, 3'd5);
        send(2'b00, 3'd2);
        for (int i = 0; i < 4; i++) send(2'b01, 3'($urandom_range(0, 7)));
        idle(1);

        // Fill the whole board, then clear it
        for (int rd = 0; rd < NUM_ROWS; rd++)
            for (int c = 0; c < NUM_COLS; c++) send(2'b00, 3'(c));
        check_val("board_full_42", int'(bus.o_board_full), 1);
        send(2'b00, 3'd4);
        idle(1);
        clear_board();

        // Back-to-back drops with valid held high
        for (int i = 0; i < 3; i++) send(2'b00, 3'd0);
        idle(1);

        // Reset on the third CLEAR cycle
        send(2'b00, 3'd4);
        send(2'b00, 3'd5);
        send(2'b00, 3'd6);
        bus.i_req_op = 2'b10;
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("midclr");
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check_val("post_rst_ready", int'(bus.o_req_ready), 1);
        check_status();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)       clear_board();
            else if (r < 62) send(2'b00, 3'($urandom_range(0, 7)));
            else if (r < 95) send(2'b01, 3'($urandom_range(0, 7)));
            else             send(2'b11, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
